// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory arbiter: FSM state and requester identity.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE,
      I_BUSY,
      D_BUSY
   } arb_state_t;

   typedef enum logic {
      ICACHE,
      DCACHE
   } arb_src_t;

   localparam logic [31:0] LINE_ADDR_MASK = 32'hFFFF_FFE0;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache line requests onto a single memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the dcache wins ties.
module mem_arbiter
   import rv32i_types::*;
#(
   parameter int unsigned LINE_BITS = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          i_addr,
   input  logic                 i_read,
   output logic [LINE_BITS-1:0] i_rdata,
   output logic                 i_resp,
   input  logic [31:0]          d_addr,
   input  logic                 d_read,
   input  logic                 d_write,
   input  logic [LINE_BITS-1:0] d_wdata,
   output logic [LINE_BITS-1:0] d_rdata,
   output logic                 d_resp,
   output logic [31:0]          mem_addr,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [LINE_BITS-1:0] mem_wdata,
   input  logic [LINE_BITS-1:0] mem_rdata,
   input  logic                 mem_resp
);

   arb_state_t           state_q, state_d;
   arb_src_t             owner_q, owner_d;
   logic [31:0]          addr_q, addr_d;
   logic                 write_q, write_d;
   logic [LINE_BITS-1:0] wdata_q, wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
   arb_src_t             last_q, last_d;
`endif

   logic     i_req, d_req, grant_valid, busy;
   arb_src_t grant_src;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      i_req       = i_read;
      d_req       = d_read | d_write;
      grant_valid = 1'b0;
      grant_src   = ICACHE;

      case (state_q)
         IDLE: begin
            if (i_req && d_req) begin
               grant_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
               grant_src   = (last_q == DCACHE) ? ICACHE : DCACHE;
`else
               grant_src   = DCACHE;
`endif
            end else if (i_req) begin
               grant_valid = 1'b1;
               grant_src   = ICACHE;
            end else if (d_req) begin
               grant_valid = 1'b1;
               grant_src   = DCACHE;
            end
         end
         I_BUSY, D_BUSY: begin
            if (mem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (grant_valid) begin
         owner_d = grant_src;
`ifdef ARB_ROUND_ROBIN_EN
         last_d  = grant_src;
`endif
         if (grant_src == ICACHE) begin
            state_d = I_BUSY;
            addr_d  = i_addr;
            write_d = 1'b0;
            wdata_d = '0;
         end else begin
            state_d = D_BUSY;
            addr_d  = d_addr;
            // a simultaneous read+write is issued as a write
            write_d = d_write;
            wdata_d = d_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= ICACHE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= DCACHE;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end

   // Port is driven purely from registered state; rst masks it so a reset
   // cycle never shows a live request or response.
   always_comb begin
      busy      = (state_q != IDLE) && !rst;
      mem_read  = busy && !write_q;
      mem_write = busy && write_q;
      mem_addr  = rst ? '0 : (addr_q & LINE_ADDR_MASK);
      mem_wdata = rst ? '0 : wdata_q;
      i_resp    = busy && mem_resp && (owner_q == ICACHE);
      d_resp    = busy && mem_resp && (owner_q == DCACHE);
      i_rdata   = mem_rdata;
      d_rdata   = mem_rdata;
   end

endmodule
